lit1: RTL and testbench
=======================

LIT1 -- requirements
Module: lit1

Interface
REQ-001 SHALL have port clk, input, 1 bit; the single clock, all state on rising edge.
REQ-002 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-003 SHALL have port wr_i, input, 1 bit; literal write strobe.
REQ-004 SHALL have port var_value_i, input, 3 bits; [2:1] variable value code, [0] implied flag.
REQ-005 SHALL have port var_value_o, output, 3 bits; implication drive toward variable, wired-OR bus, idle 3'b000.
REQ-006 SHALL have port freelitcnt_pre, input, 2 bits; free-literal count from upstream cell.
REQ-007 SHALL have port freelitcnt_next, output, 2 bits; free-literal count to downstream cell.
REQ-008 SHALL have port imp_drv_i, input, 1 bit; clause requests implication of its free literal.
REQ-009 SHALL have port conflict_c_o, output, 1 bit; this literal participates in the clause conflict.
REQ-010 SHALL have port conflict_c_drv_i, input, 1 bit; clause is in conflict.
REQ-011 SHALL have port clausesat_o, output, 1 bit; this literal satisfies the clause.

Function
REQ-012 SHALL use value code: 00 free, 01 false, 10 true, 11 conflict, for both var_value_i[2:1] and the stored literal polarity.
REQ-013 SHALL, on a clk edge with wr_i=1, load pol register <= var_value_i[2:1]; visible on outputs from the next cycle.
REQ-014 SHALL treat the literal as present only when pol is 01 (negative) or 10 (positive); 00 and 11 are absent.
REQ-015 SHALL compute lit_true = present & var in {01,10} & var code == pol; lit_free = present & var == 00.
REQ-016 SHALL drive freelitcnt_next combinationally: if lit_free, pre 00 -> 01, otherwise -> 11 (saturated "two or more"); if not lit_free, pass pre through unchanged.
REQ-017 SHALL treat freelitcnt_pre 10 as "two or more" (lit_free -> 11).
REQ-018 SHALL drive clausesat_o = lit_true.
REQ-019 SHALL drive var_value_o = {pol, 1'b1} when imp_drv_i & lit_free, else 3'b000.
REQ-020 SHALL drive conflict_c_o = conflict_c_drv_i & present & var != 00.
REQ-021 SHALL make all outputs combinational from inputs and pol; zero added latency; wr_i and rst affect outputs only after the edge.

Reset
REQ-022 SHALL clear pol to 00 on a rst=1 edge; rst overrides wr_i in the same cycle.
REQ-023 SHALL, after reset: var_value_o=000, clausesat_o=0, conflict_c_o=0, freelitcnt_next=freelitcnt_pre.

Configuration
REQ-024 SHALL, with LIT1_CONFLICT_EN defined, implement REQ-020; without it, conflict_c_o SHALL be tied 0 and conflict_c_drv_i ignored.

Structure
REQ-025 SHALL place value-code constants (FREE, FALSE, TRUE, CONFLICT) and count codes (ZERO, ONE, MANY) in a shared package used by all clause cells.
REQ-026 SHALL be a single flat module; no sub-module.

Verification
REQ-027 Reset, then write pol=10 (var_value_i[2:1]=10, wr_i=1, one cycle); var=00, pre=00 -> freelitcnt_next=01, clausesat_o=0.
REQ-028 pol=10, var=01, pre=01 -> freelitcnt_next=01, clausesat_o=0; var=10 -> clausesat_o=1, freelitcnt_next=pre.
REQ-029 pol=10, var=00, pre=01 -> freelitcnt_next=11; pre=11 -> 11; then write pol=00 -> freelitcnt_next=pre for any var.
REQ-030 pol=01, var=00, imp_drv_i=1 -> var_value_o=011; imp_drv_i=0 -> 000; var=01, imp_drv_i=1 -> 000.
REQ-031 pol=01, var=10, conflict_c_drv_i=1 -> conflict_c_o=1 (0 if LIT1_CONFLICT_EN undefined); var=00 -> 0.
REQ-032 wr_i=1 with pol=10 and rst=1 in same cycle -> pol=00; clausesat_o=0 for var=10.

Source files
------------

// File: rtl/lit1_pkg.sv
// -----------------------------------------------------------------------------
// lit1_pkg -- shared definitions for the clause-cell literal slices.
//
// The value codes are used for the variable value bus and for the stored
// literal polarity. The count codes are used on the free-literal chain that
// runs through the cells of one clause.
//   val_e : FREE / FALSE / TRUE / CONFLICT
//   cnt_e : ZERO / ONE / MANY (2'b10 on the chain is also read as "two or more")
// -----------------------------------------------------------------------------
package lit1_pkg;

  typedef enum logic [1:0] {
    FREE     = 2'b00,
    FALSE    = 2'b01,
    TRUE     = 2'b10,
    CONFLICT = 2'b11
  } val_e;

  typedef enum logic [1:0] {
    ZERO = 2'b00,
    ONE  = 2'b01,
    MANY = 2'b11
  } cnt_e;

  // A literal exists in the clause only with a definite polarity.
  function automatic logic is_present(input logic [1:0] pol);
    return (pol == FALSE) || (pol == TRUE);
  endfunction

endpackage : lit1_pkg

// File: rtl/lit1_if.sv
// -----------------------------------------------------------------------------
// lit1_if -- bundle of the per-literal signals shared between a literal cell,
// its variable and its clause.
//
// Modports:
//   master : the variable/clause side, drives strobes, values and chain input.
//   slave  : the literal cell, returns implication, chain output and status.
// -----------------------------------------------------------------------------
interface lit1_if;

  logic       wr;
  logic [2:0] var_value_i;
  logic [2:0] var_value_o;
  logic [1:0] freelitcnt_pre;
  logic [1:0] freelitcnt_next;
  logic       imp_drv;
  logic       conflict_c_o;
  logic       conflict_c_drv;
  logic       clausesat;

  modport master (
    output wr, var_value_i, freelitcnt_pre, imp_drv, conflict_c_drv,
    input  var_value_o, freelitcnt_next, conflict_c_o, clausesat
  );

  modport slave (
    input  wr, var_value_i, freelitcnt_pre, imp_drv, conflict_c_drv,
    output var_value_o, freelitcnt_next, conflict_c_o, clausesat
  );

endinterface : lit1_if

// File: rtl/lit1.sv
// -----------------------------------------------------------------------------
// lit1 -- one literal slot of a clause cell.
//
// Stores the literal polarity (pol) and derives, combinationally from the
// variable value and pol, whether the literal satisfies the clause, whether
// it is still free, the implication to drive back onto the variable, and its
// part in a clause conflict. Free literals are counted along a saturating
// two-bit chain (freelitcnt_pre -> freelitcnt_next).
//
// Ports:
//   clk              clock, all state on the rising edge
//   rst              synchronous active-high reset, clears pol
//   wr_i             load pol from var_value_i[2:1]
//   var_value_i[2:0] [2:1] variable value code, [0] implied flag
//   var_value_o[2:0] implication drive ({pol,1}), 3'b000 when idle (wired-OR)
//   freelitcnt_pre   free-literal count from the upstream cell
//   freelitcnt_next  free-literal count to the downstream cell
//   imp_drv_i        clause asks this literal to imply its value
//   conflict_c_o     literal takes part in the clause conflict
//   conflict_c_drv_i clause is in conflict
//   clausesat_o      literal satisfies the clause
//
// Configuration: define LIT1_CONFLICT_EN to enable conflict_c_o; otherwise
// it is tied low and conflict_c_drv_i is unused.
// -----------------------------------------------------------------------------
module lit1
  import lit1_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_i,
  input  logic [2:0] var_value_i,
  output logic [2:0] var_value_o,
  input  logic [1:0] freelitcnt_pre,
  output logic [1:0] freelitcnt_next,
  input  logic       imp_drv_i,
  output logic       conflict_c_o,
  input  logic       conflict_c_drv_i,
  output logic       clausesat_o
);

  logic [1:0] pol_q, pol_d;
  logic [1:0] var_code;
  logic       present;
  logic       lit_true;
  logic       lit_free;

  assign var_code = var_value_i[2:1];

  always_comb begin
    pol_d = pol_q;
    if (wr_i) pol_d = var_code;
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values; the reset branch is listed first so it overrides wr_i.
  always_ff @(posedge clk) begin
    if (rst) pol_q <= FREE;
    else     pol_q <= pol_d;
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    present         = is_present(pol_q);
    lit_true        = present && ((var_code == FALSE) || (var_code == TRUE))
                      && (var_code == pol_q);
    lit_free        = present && (var_code == FREE);
    freelitcnt_next = freelitcnt_pre;
    var_value_o     = 3'b000;
    // A free literal bumps the chain; 2'b10 and 2'b11 both mean "two or more".
    if (lit_free) freelitcnt_next = (freelitcnt_pre == ZERO) ? ONE : MANY;
    if (imp_drv_i && lit_free) var_value_o = {pol_q, 1'b1};
  end

  assign clausesat_o = lit_true;

`ifdef LIT1_CONFLICT_EN
  assign conflict_c_o = conflict_c_drv_i && present && (var_code != FREE);
`else
  logic unused_conflict_drv;
  assign unused_conflict_drv = conflict_c_drv_i;
  assign conflict_c_o        = 1'b0;
`endif

endmodule : lit1

// File: tb/tb_lit1.sv
// -----------------------------------------------------------------------------
// tb_lit1 -- directed self-checking bench for lit1.
// -----------------------------------------------------------------------------
module tb_lit1;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

`ifdef LIT1_CONFLICT_EN
  localparam logic CONF_EN = 1'b1;
`else
  localparam logic CONF_EN = 1'b0;
`endif

  lit1_if bus ();

  lit1 dut (
    .clk              (clk),
    .rst              (rst),
    .wr_i             (bus.wr),
    .var_value_i      (bus.var_value_i),
    .var_value_o      (bus.var_value_o),
    .freelitcnt_pre   (bus.freelitcnt_pre),
    .freelitcnt_next  (bus.freelitcnt_next),
    .imp_drv_i        (bus.imp_drv),
    .conflict_c_o     (bus.conflict_c_o),
    .conflict_c_drv_i (bus.conflict_c_drv),
    .clausesat_o      (bus.clausesat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Load pol with one write cycle, inputs changed away from the clock edge.
  task automatic write_pol(input logic [1:0] pol);
    bus.var_value_i = {pol, 1'b0};
    bus.wr          = 1'b1;
    @(posedge clk);
    #1;
    bus.wr = 1'b0;
  endtask

  // Apply combinational inputs and let them settle.
  task automatic apply(input logic [1:0] v, input logic [1:0] pre,
                       input logic imp, input logic drv);
    bus.var_value_i    = {v, 1'b0};
    bus.freelitcnt_pre = pre;
    bus.imp_drv        = imp;
    bus.conflict_c_drv = drv;
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst                = 1'b1;
    bus.wr             = 1'b0;
    bus.var_value_i    = 3'b000;
    bus.freelitcnt_pre = 2'b00;
    bus.imp_drv        = 1'b0;
    bus.conflict_c_drv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state: pol absent, everything idle, chain passes through.
    apply(2'b00, 2'b01, 1'b1, 1'b1);
    check("rst_var_o", 8'(bus.var_value_o), 8'h00);
    check("rst_sat", 8'(bus.clausesat), 8'h00);
    check("rst_conf", 8'(bus.conflict_c_o), 8'h00);
    check("rst_cnt", 8'(bus.freelitcnt_next), 8'h01);

    // Positive literal.
    write_pol(2'b10);
    apply(2'b00, 2'b00, 1'b0, 1'b0);
    check("p_free_cnt0", 8'(bus.freelitcnt_next), 8'h01);
    check("p_free_sat", 8'(bus.clausesat), 8'h00);
    check("p_free_noimp", 8'(bus.var_value_o), 8'h00);
    apply(2'b01, 2'b01, 1'b0, 1'b0);
    check("p_false_cnt", 8'(bus.freelitcnt_next), 8'h01);
    check("p_false_sat", 8'(bus.clausesat), 8'h00);
    apply(2'b10, 2'b01, 1'b0, 1'b0);
    check("p_true_sat", 8'(bus.clausesat), 8'h01);
    check("p_true_cnt", 8'(bus.freelitcnt_next), 8'h01);
    apply(2'b10, 2'b10, 1'b0, 1'b0);
    check("p_true_cnt10", 8'(bus.freelitcnt_next), 8'h02);
    apply(2'b00, 2'b01, 1'b0, 1'b0);
    check("p_free_cnt1", 8'(bus.freelitcnt_next), 8'h03);
    apply(2'b00, 2'b11, 1'b0, 1'b0);
    check("p_free_cnt3", 8'(bus.freelitcnt_next), 8'h03);
    apply(2'b00, 2'b10, 1'b0, 1'b0);
    check("p_free_cnt2", 8'(bus.freelitcnt_next), 8'h03);
    apply(2'b11, 2'b00, 1'b0, 1'b0);
    check("p_vconf_sat", 8'(bus.clausesat), 8'h00);
    check("p_vconf_cnt", 8'(bus.freelitcnt_next), 8'h00);

    // Absent literal (pol 00, then pol 11): chain passes, never satisfies.
    write_pol(2'b00);
    for (int v = 0; v < 4; v++) begin
      apply(2'(v), 2'b01, 1'b1, 1'b0);
      check($sformatf("abs0_cnt_v%0d", v), 8'(bus.freelitcnt_next), 8'h01);
      check($sformatf("abs0_sat_v%0d", v), 8'(bus.clausesat), 8'h00);
    end
    write_pol(2'b11);
    apply(2'b00, 2'b00, 1'b1, 1'b1);
    check("abs3_cnt", 8'(bus.freelitcnt_next), 8'h00);
    check("abs3_var_o", 8'(bus.var_value_o), 8'h00);
    check("abs3_conf", 8'(bus.conflict_c_o), 8'h00);

    // Negative literal: implication drive.
    write_pol(2'b01);
    apply(2'b00, 2'b00, 1'b1, 1'b0);
    check("n_imp", 8'(bus.var_value_o), 8'h03);
    apply(2'b00, 2'b00, 1'b0, 1'b0);
    check("n_noimp", 8'(bus.var_value_o), 8'h00);
    apply(2'b01, 2'b00, 1'b1, 1'b0);
    check("n_assigned_imp", 8'(bus.var_value_o), 8'h00);
    check("n_false_sat", 8'(bus.clausesat), 8'h01);

    // Conflict participation.
    apply(2'b10, 2'b00, 1'b0, 1'b1);
    check("n_conf_v10", 8'(bus.conflict_c_o), 8'(CONF_EN));
    apply(2'b11, 2'b00, 1'b0, 1'b1);
    check("n_conf_v11", 8'(bus.conflict_c_o), 8'(CONF_EN));
    apply(2'b10, 2'b00, 1'b0, 1'b0);
    check("n_conf_nodrv", 8'(bus.conflict_c_o), 8'h00);
    apply(2'b00, 2'b00, 1'b0, 1'b1);
    check("n_conf_free", 8'(bus.conflict_c_o), 8'h00);

    // Write takes effect only after the edge.
    apply(2'b00, 2'b00, 1'b0, 1'b0);
    bus.var_value_i = 3'b100;
    bus.wr          = 1'b1;
    #1;
    check("wr_pre_edge_sat", 8'(bus.clausesat), 8'h00);
    @(posedge clk);
    #1;
    bus.wr = 1'b0;
    #1;
    check("wr_post_edge_sat", 8'(bus.clausesat), 8'h01);

    // Reset overrides a simultaneous write; effect only after the edge.
    write_pol(2'b01);
    bus.var_value_i = 3'b010;
    bus.wr          = 1'b1;
    rst             = 1'b1;
    #1;
    check("rst_pre_edge_sat", 8'(bus.clausesat), 8'h01);
    @(posedge clk);
    #1;
    bus.wr = 1'b0;
    rst    = 1'b0;
    #1;
    check("rst_post_edge_sat", 8'(bus.clausesat), 8'h00);

    bus.var_value_i = 3'b100;
    bus.wr          = 1'b1;
    rst             = 1'b1;
    @(posedge clk);
    #1;
    bus.wr = 1'b0;
    rst    = 1'b0;
    apply(2'b10, 2'b00, 1'b0, 1'b0);
    check("rst_wr_sat", 8'(bus.clausesat), 8'h00);
    apply(2'b00, 2'b00, 1'b1, 1'b0);
    check("rst_wr_cnt", 8'(bus.freelitcnt_next), 8'h00);
    check("rst_wr_var_o", 8'(bus.var_value_o), 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_lit1
